vec_feeder: RTL and testbench

VEC_FEEDER -- requirements
Module: vec_feeder

---
 rtl/vec_pkg.sv | 22 ++
 rtl/vec_pair_buf.sv | 37 +++
 rtl/vec_feeder.sv | 119 +++++++++++
 tb/tb_vec_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector feeder: parameter defaults, FSM states
// and the helper that sizes the pair index counters.
package vec_pkg;

    localparam int unsigned VEC_LEN_DEF = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ACC_W_DEF   = 32;

    // Index counter width for a vector of pairs (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(VEC_LEN_DEF);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } vec_state_e;

endpackage

// File: rtl/vec_pair_buf.sv
// Pair storage for one dot-product vector.
// Ports: clk_i; write port (wr_en_i, wr_addr_i, wr_input_i, wr_weight_i);
//        read port (rd_addr_i -> rd_input_c, rd_weight_c, combinational).
// Contents are never cleared; each load simply overwrites.
module vec_pair_buf
    import vec_pkg::*;
#(
    parameter int unsigned DEPTH  = VEC_LEN_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned AW     = cnt_width(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic signed [DATA_W-1:0] wr_input_i,
    input  logic signed [DATA_W-1:0] wr_weight_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic signed [DATA_W-1:0] rd_input_c,
    output logic signed [DATA_W-1:0] rd_weight_c
);

    logic signed [DATA_W-1:0] input_mem  [DEPTH];
    logic signed [DATA_W-1:0] weight_mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            input_mem[wr_addr_i]  <= wr_input_i;
            weight_mem[wr_addr_i] <= wr_weight_i;
        end
    end

    // Read port; the feeder registers it before it leaves the block.
    assign rd_input_c  = input_mem[rd_addr_i];
    assign rd_weight_c = weight_mem[rd_addr_i];

endmodule

// File: rtl/vec_feeder.sv
// Loads VEC_LEN (input, weight) pairs, streams them to a MAC one per cycle,
// then waits for the MAC result and captures it.
// Ports: clk_i, rst_i (sync, active high);
//        load_valid_i/load_input_i/load_weight_i/load_ready_o: pair loading;
//        dsp_enable_o/dsp_input_o/dsp_weight_o/dsp_valid_o: registered MAC feed,
//        dsp_valid_o flags the last pair;
//        mac_valid_i/mac_result_i: MAC result return;
//        result_o/result_valid_o: captured dot product and its one-cycle strobe.
module vec_feeder
    import vec_pkg::*;
#(
    parameter int unsigned VEC_LEN = VEC_LEN_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_valid_i,
    input  logic signed [DATA_W-1:0] load_input_i,
    input  logic signed [DATA_W-1:0] load_weight_i,
    output logic                     load_ready_o,
    output logic                     dsp_enable_o,
    output logic signed [DATA_W-1:0] dsp_input_o,
    output logic signed [DATA_W-1:0] dsp_weight_o,
    output logic                     dsp_valid_o,
    input  logic                     mac_valid_i,
    input  logic signed [ACC_W-1:0]  mac_result_i,
    output logic signed [ACC_W-1:0]  result_o,
    output logic                     result_valid_o
);

    localparam int unsigned CNT_W = cnt_width(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    vec_state_e       state_q, state_d;
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] issue_cnt_q;

    logic                     load_fire;
    logic                     load_last;
    logic                     issuing;
    logic                     issue_last;
    logic                     capture;
    logic signed [DATA_W-1:0] buf_input;
    logic signed [DATA_W-1:0] buf_weight;

    assign load_fire  = (state_q == ST_LOAD) && load_valid_i;
    assign load_last  = load_fire && (load_cnt_q == LAST_IDX);
    assign issuing    = (state_q == ST_ISSUE);
    assign issue_last = issuing && (issue_cnt_q == LAST_IDX);
    assign capture    = (state_q == ST_WAIT) && mac_valid_i;

    vec_pair_buf #(
        .DEPTH  (VEC_LEN),
        .DATA_W (DATA_W),
        .AW     (CNT_W)
    ) u_pair_buf (
        .clk_i       (clk_i),
        .wr_en_i     (load_fire),
        .wr_addr_i   (load_cnt_q),
        .wr_input_i  (load_input_i),
        .wr_weight_i (load_weight_i),
        .rd_addr_i   (issue_cnt_q),
        .rd_input_c  (buf_input),
        .rd_weight_c (buf_weight)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (load_last)  state_d = ST_ISSUE;
            ST_ISSUE: if (issue_last) state_d = ST_WAIT;
            ST_WAIT:  if (capture)    state_d = ST_LOAD;
            default:                  state_d = ST_LOAD;
        endcase
    end

    // State and pair index counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_fire) begin
                load_cnt_q <= load_last ? '0 : load_cnt_q + CNT_W'(1);
            end
            if (issuing) begin
                issue_cnt_q <= issue_last ? '0 : issue_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output registers; the issued pair lands on dsp_* one cycle after its read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_ready_o   <= 1'b1;
            dsp_enable_o   <= 1'b0;
            dsp_input_o    <= '0;
            dsp_weight_o   <= '0;
            dsp_valid_o    <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            load_ready_o   <= (state_d == ST_LOAD);
            dsp_enable_o   <= issuing;
            dsp_input_o    <= issuing ? buf_input  : '0;
            dsp_weight_o   <= issuing ? buf_weight : '0;
            dsp_valid_o    <= issue_last;
            result_valid_o <= capture;
            if (capture) begin
                result_o <= mac_result_i;
            end
        end
    end

endmodule

// File: tb/tb_vec_feeder.sv
// Bench for vec_feeder: a per-cycle expectation schedule built from the
// loaded vectors and the MAC/reset events, checked on every falling edge,
// plus hand-computed spot checks.
module tb_vec_feeder;

    localparam int VL   = 8;
    localparam int NCYC = 1024;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              load_valid_i;
    logic signed [7:0] load_input_i;
    logic signed [7:0] load_weight_i;
    logic              load_ready_o;
    logic              dsp_enable_o;
    logic signed [7:0] dsp_input_o;
    logic signed [7:0] dsp_weight_o;
    logic              dsp_valid_o;
    logic              mac_valid_i;
    logic signed [31:0] mac_result_i;
    logic signed [31:0] result_o;
    logic              result_valid_o;

    vec_feeder #(.VEC_LEN(VL), .DATA_W(8), .ACC_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_valid_i   (load_valid_i),
        .load_input_i   (load_input_i),
        .load_weight_i  (load_weight_i),
        .load_ready_o   (load_ready_o),
        .dsp_enable_o   (dsp_enable_o),
        .dsp_input_o    (dsp_input_o),
        .dsp_weight_o   (dsp_weight_o),
        .dsp_valid_o    (dsp_valid_o),
        .mac_valid_i    (mac_valid_i),
        .mac_result_i   (mac_result_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs per cycle index.
    bit e_en [NCYC];
    int e_in [NCYC];
    int e_wt [NCYC];
    bit e_dv [NCYC];
    bit e_rv [NCYC];
    bit e_rdy[NCYC];
    bit e_rset[NCYC];
    int e_rval[NCYC];

    int q_in[$];
    int q_wt[$];
    int vec_in[VL];
    int vec_wt[VL];
    int ld_in[VL];
    int ld_wt[VL];
    bit in_load    = 1'b1;
    int wait_start = NCYC;
    int last_k     = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit done   = 1'b0;
    logic signed [31:0] exp_res = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the schedule.
    always @(negedge clk_i) begin
        if (!done && cyc >= 1 && cyc < NCYC) begin
            if (e_rset[cyc]) exp_res = 32'(e_rval[cyc]);
            chk("load_ready",   load_ready_o,   e_rdy[cyc]);
            chk("dsp_enable",   dsp_enable_o,   e_en[cyc]);
            chk("dsp_input",    dsp_input_o,    e_in[cyc]);
            chk("dsp_weight",   dsp_weight_o,   e_wt[cyc]);
            chk("dsp_valid",    dsp_valid_o,    e_dv[cyc]);
            chk("result_valid", result_valid_o, e_rv[cyc]);
            chk("result",       result_o,       exp_res);
        end
    end

    // Full vector loaded in cycle k: pairs stream in cycles k+2 .. k+1+VL,
    // loading closes from k+1 and results are accepted from k+1+VL on.
    task automatic model_issue(input int k);
        for (int j = 0; j < VL; j++) begin
            int c = k + 2 + j;
            vec_in[j] = q_in[j];
            vec_wt[j] = q_wt[j];
            if (c < NCYC) begin
                e_en[c] = 1'b1;
                e_in[c] = q_in[j];
                e_wt[c] = q_wt[j];
                e_dv[c] = (j == VL - 1);
            end
        end
        for (int c = k + 1; c < NCYC; c++) e_rdy[c] = 1'b0;
        in_load    = 1'b0;
        wait_start = k + 1 + VL;
        last_k     = k;
        q_in.delete();
        q_wt.delete();
    endtask

    task automatic model_capture(input int m, input int r);
        if (m + 1 < NCYC) begin
            e_rv[m + 1]   = 1'b1;
            e_rset[m + 1] = 1'b1;
            e_rval[m + 1] = r;
        end
        for (int c = m + 1; c < NCYC; c++) e_rdy[c] = 1'b1;
        in_load    = 1'b1;
        wait_start = NCYC;
    endtask

    task automatic model_reset(input int r);
        for (int c = r + 1; c < NCYC; c++) begin
            e_en[c] = 1'b0; e_in[c] = 0; e_wt[c] = 0; e_dv[c] = 1'b0;
            e_rv[c] = 1'b0; e_rdy[c] = 1'b1; e_rset[c] = 1'b0;
        end
        if (r + 1 < NCYC) begin
            e_rset[r + 1] = 1'b1;
            e_rval[r + 1] = 0;
        end
        in_load    = 1'b1;
        wait_start = NCYC;
        q_in.delete();
        q_wt.delete();
    endtask

    // Drive one cycle of inputs, update the schedule, advance past the edge.
    task automatic step(input bit lv, input int li, input int lw,
                        input bit mv, input int mr, input bit rs);
        int n;
        n             = cyc;
        rst_i         = rs;
        load_valid_i  = lv;
        load_input_i  = 8'(li);
        load_weight_i = 8'(lw);
        mac_valid_i   = mv;
        mac_result_i  = 32'(mr);
        if (rs) begin
            model_reset(n);
        end else begin
            if (lv && in_load) begin
                q_in.push_back(li);
                q_wt.push_back(lw);
                if (q_in.size() == VL) model_issue(n);
            end
            if (mv && !in_load && n >= wait_start) model_capture(n, mr);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic mac(input int r);
        step(1'b0, 0, 0, 1'b1, r, 1'b0);
    endtask

    task automatic load_vec(input bit gap);
        for (int i = 0; i < VL; i++) begin
            step(1'b1, ld_in[i], ld_wt[i], 1'b0, 0, 1'b0);
            if (gap && i < VL - 1) step(1'b0, 99, 99, 1'b0, 0, 1'b0);
        end
    endtask

    function automatic int dot();
        int s = 0;
        for (int i = 0; i < VL; i++) s += vec_in[i] * vec_wt[i];
        return s;
    endfunction

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            e_en[c] = 1'b0; e_in[c] = 0; e_wt[c] = 0; e_dv[c] = 1'b0;
            e_rv[c] = 1'b0; e_rdy[c] = 1'b1; e_rset[c] = 1'b0; e_rval[c] = 0;
        end

        repeat (3) step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        chk("lit_rst_ready",  load_ready_o,   1);
        chk("lit_rst_enable", dsp_enable_o,   0);
        chk("lit_rst_result", result_o,       0);
        chk("lit_rst_rvalid", result_valid_o, 0);
        idle(1);
        chk("lit_ready_after_release", load_ready_o, 1);

        // Inputs 1..8, weights -1, back to back.
        for (int i = 0; i < VL; i++) begin ld_in[i] = i + 1; ld_wt[i] = -1; end
        load_vec(1'b0);
        idle(1);
        chk("lit_first_en",  dsp_enable_o, 1);
        chk("lit_first_in",  dsp_input_o,  1);
        chk("lit_first_wt",  dsp_weight_o, -1);
        chk("lit_first_dv",  dsp_valid_o,  0);
        idle(6);
        chk("lit_7th_in", dsp_input_o, 7);
        chk("lit_7th_dv", dsp_valid_o, 0);
        idle(1);
        chk("lit_last_in", dsp_input_o, 8);
        chk("lit_last_dv", dsp_valid_o, 1);
        chk("lit_dot_a",   dot(),       -36);
        mac(-36);
        chk("lit_res",       result_o,       -36);
        chk("lit_res_valid", result_valid_o, 1);
        chk("lit_res_ready", load_ready_o,   1);
        idle(1);
        chk("lit_res_pulse", result_valid_o, 0);
        chk("lit_res_hold",  result_o,       -36);

        // Loads with gaps, then a long stay in WAIT.
        for (int i = 0; i < VL; i++) begin ld_in[i] = i * 3 - 10; ld_wt[i] = 5 - 2 * i; end
        load_vec(1'b1);
        idle(VL + 15);
        mac(dot());
        idle(2);

        // Stray loads and MAC strobes while issuing, a stray load while waiting.
        for (int i = 0; i < VL; i++) begin ld_in[i] = 100 - 25 * i; ld_wt[i] = i - 4; end
        load_vec(1'b0);
        repeat (4) step(1'b1, 55, -55, 1'b1, 777, 1'b0);
        idle(4);
        step(1'b1, 11, 11, 1'b0, 0, 1'b0);
        mac(dot());
        idle(2);

        // Reset while the 4th pair is on the outputs, then an extreme vector.
        for (int i = 0; i < VL; i++) begin ld_in[i] = i * 7 - 20; ld_wt[i] = 3 + i; end
        load_vec(1'b0);
        idle(4);
        chk("lit_4th_in", dsp_input_o, 1);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        chk("lit_abort_en",    dsp_enable_o, 0);
        chk("lit_abort_in",    dsp_input_o,  0);
        chk("lit_abort_wt",    dsp_weight_o, 0);
        chk("lit_abort_dv",    dsp_valid_o,  0);
        chk("lit_abort_ready", load_ready_o, 1);
        for (int i = 0; i < VL; i++) begin
            ld_in[i] = (i % 2 == 0) ? 127 : -128;
            ld_wt[i] = (i % 2 == 0) ? -128 : 127;
        end
        load_vec(1'b0);
        idle(VL);
        chk("lit_dot_e", dot(), -130048);
        mac(dot());
        idle(2);

        // Two vectors back to back, second load starting on the result pulse.
        for (int i = 0; i < VL; i++) begin ld_in[i] = 2 * i - 7; ld_wt[i] = 9 - i; end
        load_vec(1'b0);
        idle(VL);
        mac(dot());
        chk("lit_b2b_rvalid", result_valid_o, 1);
        for (int i = 0; i < VL; i++) begin ld_in[i] = -3 * i; ld_wt[i] = 2 * i + 1; end
        load_vec(1'b0);
        idle(VL);
        mac(dot());
        idle(3);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
